task_dispatch_arb: RTL

TASK_DISPATCH_ARB -- requirements
Module: task_dispatch_arb

---
 rtl/task_dispatch_pkg.sv | 22 ++
 rtl/task_fifo.sv | 55 +++++
 rtl/task_dispatch_arb.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/task_dispatch_pkg.sv
// Shared defaults, width helpers and the queued task entry layout
// for the task dispatch arbiter.
package task_dispatch_pkg;
  localparam int DEF_PTW       = 16;
  localparam int DEF_MTW       = 0;
  localparam int DEF_LEVEL     = 4;
  localparam int DEF_TREE_NUM  = 8;
  localparam int DEF_FIFO_SIZE = 8;
  localparam int TASK_TID_W    = $clog2(DEF_TREE_NUM);
  localparam int TASK_DW       = DEF_MTW + DEF_PTW;

  typedef struct packed {
    logic                  push;
    logic                  pop;
    logic [TASK_TID_W-1:0] tree_id;
    logic [TASK_DW-1:0]    data;
  } task_entry_t;

  function automatic int entry_width(input int tid_w, input int dw);
    return 2 + tid_w + dw;
  endfunction
endpackage

// File: rtl/task_fifo.sv
// Synchronous task FIFO with occupancy count, full and almost-full flags.
// The head entry is presented combinationally on o_rdata.
module task_fifo
  import task_dispatch_pkg::*;
#(
  parameter int WIDTH    = entry_width(TASK_TID_W, TASK_DW),
  parameter int DEPTH    = DEF_FIFO_SIZE,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_afull,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (i_wr) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_wr) r_wptr <= r_wptr + 1'b1;
      if (i_rd) r_rptr <= r_rptr + 1'b1;
      case ({i_wr, i_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_afull = (r_count >= CW'(AFULL_TH));
  assign o_count = r_count;
endmodule

// File: rtl/task_dispatch_arb.sv
// Per-port task queues feeding LEVEL RPU slots; heads compete per slot
// under stall, per-tree cooldown and ring-stage hazard constraints.
module task_dispatch_arb
  import task_dispatch_pkg::*;
#(
  parameter int PTW       = DEF_PTW,
  parameter int MTW       = DEF_MTW,
  parameter int LEVEL     = DEF_LEVEL,
  parameter int TREE_NUM  = DEF_TREE_NUM,
  parameter int FIFO_SIZE = DEF_FIFO_SIZE,
  parameter int AFULL_TH  = FIFO_SIZE - 2
) (
  input  logic                                   i_clk,
  input  logic                                   i_arst_n,
  input  logic [LEVEL-1:0]                       i_push,
  input  logic [LEVEL-1:0]                       i_pop,
  input  logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0] i_push_tree_id,
  input  logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0] i_pop_tree_id,
  input  logic [LEVEL-1:0][MTW+PTW-1:0]          i_push_data,
  input  logic                                   i_stall,
  output logic [LEVEL-1:0]                       o_task_fifo_full,
  output logic [LEVEL-1:0]                       o_task_fifo_afull,
  output logic [LEVEL-1:0][$clog2(FIFO_SIZE):0]  o_fifo_count,
  output logic [LEVEL-1:0]                       o_drop,
  output logic [LEVEL-1:0]                       o_rpu_push,
  output logic [LEVEL-1:0]                       o_rpu_pop,
  output logic [LEVEL-1:0][$clog2(TREE_NUM)-1:0] o_rpu_tree_id,
  output logic [LEVEL-1:0][MTW+PTW-1:0]          o_rpu_push_data
);
  localparam int TID_W  = $clog2(TREE_NUM);
  localparam int DW     = MTW + PTW;
  localparam int SLOT_W = $clog2(LEVEL);
  localparam int EW     = entry_width(TID_W, DW);
  localparam logic [SLOT_W-1:0] CD_INIT = SLOT_W'(LEVEL - 1);

  typedef struct packed {
    logic             push;
    logic             pop;
    logic [TID_W-1:0] tree_id;
    logic [DW-1:0]    data;
  } entry_t;

  entry_t [LEVEL-1:0]              w_wentry;
  entry_t [LEVEL-1:0]              w_head;
  entry_t [LEVEL-1:0]              w_win;
  logic   [LEVEL-1:0]              w_wr;
  logic   [LEVEL-1:0]              w_rd;
  logic   [LEVEL-1:0]              w_empty;
  logic   [LEVEL-1:0]              w_full;
  logic   [LEVEL-1:0]              w_reject;
  logic   [LEVEL-1:0]              w_elig;
  logic   [LEVEL-1:0][SLOT_W-1:0]  w_slot;
  logic   [LEVEL-1:0]              w_blocked;
  logic   [LEVEL-1:0]              w_gnt_vld;
  logic   [LEVEL-1:0][SLOT_W-1:0]  w_gnt_port;
  logic   [TREE_NUM-1:0]           w_cd_load;

  logic   [LEVEL-2:0][LEVEL-1:0]   r_hist;
  logic   [LEVEL-1:0][SLOT_W-1:0]  r_rr;
  logic   [TREE_NUM-1:0][SLOT_W-1:0] r_cd;
  logic   [LEVEL-1:0]              r_drop;
  logic   [LEVEL-1:0]              r_rpu_push;
  logic   [LEVEL-1:0]              r_rpu_pop;
  logic   [LEVEL-1:0][TID_W-1:0]   r_rpu_tid;
  logic   [LEVEL-1:0][DW-1:0]      r_rpu_data;

  for (genvar p = 0; p < LEVEL; p++) begin : g_port
    // A push+pop pair is only mergeable when both target the same tree.
    assign w_reject[p] = (i_push[p] | i_pop[p]) &
                         (w_full[p] | (i_push[p] & i_pop[p] &
                          (i_push_tree_id[p] != i_pop_tree_id[p])));
    assign w_wr[p]     = (i_push[p] | i_pop[p]) & ~w_reject[p];

    assign w_wentry[p].push    = i_push[p];
    assign w_wentry[p].pop     = i_pop[p];
    assign w_wentry[p].tree_id = i_push[p] ? i_push_tree_id[p] : i_pop_tree_id[p];
    assign w_wentry[p].data    = i_push[p] ? i_push_data[p] : {DW{1'b1}};

    assign w_slot[p] = w_head[p].tree_id[SLOT_W-1:0];
    assign w_elig[p] = ~w_empty[p] & ~i_stall &
                       (r_cd[w_head[p].tree_id] == '0) & ~w_blocked[w_slot[p]];
    assign w_rd[p]   = w_gnt_vld[w_slot[p]] & (w_gnt_port[w_slot[p]] == SLOT_W'(p));

    task_fifo #(
      .WIDTH    (EW),
      .DEPTH    (FIFO_SIZE),
      .AFULL_TH (AFULL_TH)
    ) u_fifo (
      .i_clk    (i_clk),
      .i_arst_n (i_arst_n),
      .i_wr     (w_wr[p]),
      .i_wdata  (w_wentry[p]),
      .i_rd     (w_rd[p]),
      .o_rdata  (w_head[p]),
      .o_empty  (w_empty[p]),
      .o_full   (w_full[p]),
      .o_afull  (o_task_fifo_afull[p]),
      .o_count  (o_fifo_count[p])
    );
  end

  // r_hist[k-1] holds the issue vector that is k cycles older than the candidate issue.
  always_comb begin
    w_blocked = '0;
    for (int s = 0; s < LEVEL; s++) begin
      for (int k = 1; k < LEVEL; k++) begin
        if (r_hist[k-1][(s - k + LEVEL) % LEVEL]) w_blocked[s] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [SLOT_W-1:0] w_idx;
    w_gnt_vld  = '0;
    w_gnt_port = '0;
    w_idx      = '0;
    for (int s = 0; s < LEVEL; s++) begin
      for (int i = 0; i < LEVEL; i++) begin
        w_idx = r_rr[s] + SLOT_W'(i);
        if (!w_gnt_vld[s] && w_elig[w_idx] && (w_slot[w_idx] == SLOT_W'(s))) begin
          w_gnt_vld[s]  = 1'b1;
          w_gnt_port[s] = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_cd_load = '0;
    w_win     = '0;
    for (int s = 0; s < LEVEL; s++) begin
      w_win[s] = w_head[w_gnt_port[s]];
      if (w_gnt_vld[s]) w_cd_load[w_win[s].tree_id] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_drop     <= '0;
      r_hist     <= '0;
      r_rr       <= '0;
      r_cd       <= '0;
      r_rpu_push <= '0;
      r_rpu_pop  <= '0;
      r_rpu_tid  <= '0;
      r_rpu_data <= '0;
    end else begin
      r_drop    <= w_reject;
      r_hist[0] <= w_gnt_vld;
      for (int k = 1; k < LEVEL - 1; k++) r_hist[k] <= r_hist[k-1];
      for (int s = 0; s < LEVEL; s++) begin
        r_rpu_push[s] <= w_gnt_vld[s] & w_win[s].push;
        r_rpu_pop[s]  <= w_gnt_vld[s] & w_win[s].pop;
        r_rpu_tid[s]  <= w_gnt_vld[s] ? w_win[s].tree_id : '0;
        r_rpu_data[s] <= w_gnt_vld[s] ? w_win[s].data : '0;
        if (w_gnt_vld[s]) r_rr[s] <= w_gnt_port[s] + 1'b1;
      end
      // Cooldown holds its value while stalled so a stall never shortens the gap.
      for (int j = 0; j < TREE_NUM; j++) begin
        if (w_cd_load[j])                      r_cd[j] <= CD_INIT;
        else if (!i_stall && r_cd[j] != '0)    r_cd[j] <= r_cd[j] - 1'b1;
      end
    end
  end

  assign o_task_fifo_full = w_full;
  assign o_drop           = r_drop;
  assign o_rpu_push       = r_rpu_push;
  assign o_rpu_pop        = r_rpu_pop;
  assign o_rpu_tree_id    = r_rpu_tid;
  assign o_rpu_push_data  = r_rpu_data;
endmodule
